wiscsc15_pipe_ctrl: RTL
=======================

Name: wiscsc15_pipe_ctrl

Overview:
- Pipelined control unit for the 5-stage WISC-SC15 core (IF/ID/EX/MEM/WB).
- Decodes the ID-stage opcode into per-stage control bundles and carries them through registered ID/EX, EX/MEM and MEM/WB stages.
- Detects load-use and RAW hazards, squashes wrong-path instructions on branch/call/ret, and freezes the pipe on data-memory wait states.

Parameters:
RA_W, 4, register-index width
SP_IDX, 15, register index used as stack pointer by call/ret
FLUSH_CYC, 1, cycles flush_id stays asserted after a redirect (legal 1..3)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID holds a real instruction
id_opcode  input  4  ID opcode
id_rs1  input  RA_W  source 1 index
id_rs2  input  RA_W  source 2 index
id_rd  input  RA_W  destination index
ex_branch_taken  input  1  EX branch condition true (qualified internally by EX sel_branch)
dm_ready  input  1  data memory completes access this cycle
id_rf_rsrc  output  4  {rsrc1[1:0], rsrc2[1:0]}, combinational from id_opcode
stall_if  output  1  hold PC and IF/ID register
flush_id  output  1  load NOP into IF/ID
ex_ctrl  output  9  {pc_src, sel_call, sel_branch, alu_src1, alu_src2[1:0], aluop[2:0]}
mem_ctrl  output  2  {dm_read, dm_write}
wb_ctrl  output  4  {rf_w, rf_wsrc, rf_data[1:0]}
wb_rd  output  RA_W  write-back register index
illegal_op  output  1  one-cycle pulse when opcode 1111 with id_valid leaves ID

Behaviour:
- Reset (rst_n low, async): all stage registers hold bubbles. ex_ctrl=0, mem_ctrl=0, wb_ctrl=4'b0011, wb_rd=0, stall_if=0, flush_id=0, illegal_op=0, flush counter=0.
- Decode: 00xx arith, aluop=op[2:0]. 0100 inc alu_src2=10. 0101/011x shifts alu_src2=01. 1000 lw alu_src1=1, alu_src2=11, dm_read, rf_data=00. 1001 sw dm_write, rf_w=0. 1010 lhb rf_data=01. 1011 llb rf_data=10. 1100 b sel_branch, rf_w=0. 1101 call sel_call, dm_write, rf_w, rf_wsrc=0, aluop=001. 1110 ret pc_src, dm_read, rf_w, rf_wsrc=0, aluop=000.
- Unused fields are driven 0, never x. Opcode 1111 decodes to a bubble.
- Sources used: rs1 for opcodes 0000-1011. rs2 for 00xx and 1001. SP_IDX for call/ret. b uses no source.
- Latency: ID→EX, EX→MEM and MEM→WB are each 1 cycle. The bubble encoding is all control = 0, rd = 0.
- Memory stall (highest priority): MEM holds dm_read or dm_write and dm_ready=0.
  - IF, ID, EX and MEM hold.
  - WB receives a bubble; stall_if=1.
  - Redirect and hazard logic is frozen.
- Redirect: EX holds (sel_branch & ex_branch_taken), sel_call, or pc_src.
  - EX receives a bubble next cycle.
  - flush_id is asserted for FLUSH_CYC consecutive cycles, counted by the down-counter.
  - A new redirect reloads the counter.
- Load-use (no memory stall, no redirect): EX holds dm_read with rf_w=1, EX rd ≠ 0 matches a used ID source, and id_valid=1.
  - stall_if=1 for 1 cycle; a bubble is inserted into EX.
- Simultaneous redirect and load-use: redirect wins; stall_if=0.
- Register 0 never causes a hazard. id_valid=0 never causes a stall.

Optional Feature:
FORWARD_EN
- Defined: adds outputs fwd_a[1:0] and fwd_b[1:0] (00 = RF, 01 = EX/MEM, 10 = MEM/WB) for the EX operands. Priority goes to the youngest writer.
  - Only load-use stalls remain.
- Undefined: no forwarding ports. Any used ID source matching a valid rf_w rd in EX, MEM or WB stalls ID (stall_if=1, EX bubble) until the writer has retired WB.

Test Plan:
- Reset: rst_n=0 mid-stream with lw in MEM → next edge wb_ctrl=4'b0011, mem_ctrl=0, ex_ctrl=0, stall_if=0.
- Load-use: lw r3 then add r4,r3,r5 → stall_if=1 exactly 1 cycle. EX shows a bubble, then add; with FORWARD_EN, fwd_a=10 on the add in EX.
- Branch taken: b in EX, ex_branch_taken=1, FLUSH_CYC=2 → flush_id high 2 cycles, EX bubble next cycle, no rf_w from squashed instructions.
- Memory wait: sw in MEM, dm_ready low 3 cycles → all stages hold 3 cycles, WB gets 3 bubbles, sw completes on the 4th.
- Call/ret: call → ex_ctrl sel_call=1, mem_ctrl=01, wb rf_wsrc=0. ret → pc_src=1, mem_ctrl=10, flush_id asserted.
- Illegal: opcode 1111 with id_valid=1 → illegal_op pulses 1 cycle, all downstream control 0; r0 destination produces no stall.

Source files
------------

// File: rtl/wiscsc15_pipe_ctrl.sv
// WISC-SC15 pipelined control unit: ID decode, ID/EX, EX/MEM and MEM/WB control
// registers, hazard detection, redirect flush and data-memory wait freeze.
// Optional build macro: FORWARD_EN (adds fwd_a/fwd_b and keeps only load-use stalls).

package wiscsc15_pipe_ctrl_pkg;

  typedef struct packed {
    logic       pc_src;
    logic       sel_call;
    logic       sel_branch;
    logic       alu_src1;
    logic [1:0] alu_src2;
    logic [2:0] aluop;
  } ex_ctrl_t;

  typedef struct packed {
    logic dm_read;
    logic dm_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic       rf_w;
    logic       rf_wsrc;
    logic [1:0] rf_data;
  } wb_ctrl_t;

  // rf_data 11 selects the ALU result; rf_wsrc 1 writes rd, 0 writes the stack pointer
  localparam wb_ctrl_t WB_RESET = '{rf_w: 1'b0, rf_wsrc: 1'b0, rf_data: 2'b11};
  localparam wb_ctrl_t WB_ALU   = '{rf_w: 1'b1, rf_wsrc: 1'b1, rf_data: 2'b11};
  localparam wb_ctrl_t WB_MEM   = '{rf_w: 1'b1, rf_wsrc: 1'b1, rf_data: 2'b00};
  localparam wb_ctrl_t WB_LHB   = '{rf_w: 1'b1, rf_wsrc: 1'b1, rf_data: 2'b01};
  localparam wb_ctrl_t WB_LLB   = '{rf_w: 1'b1, rf_wsrc: 1'b1, rf_data: 2'b10};
  localparam wb_ctrl_t WB_SP    = '{rf_w: 1'b1, rf_wsrc: 1'b0, rf_data: 2'b11};

  // register-file read source select per port
  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_RS   = 2'b01;
  localparam logic [1:0] SRC_SP   = 2'b10;

  localparam logic [3:0] OP_ILL = 4'b1111;

endpackage

module wiscsc15_pipe_ctrl
  import wiscsc15_pipe_ctrl_pkg::*;
#(
  parameter int unsigned RA_W      = 4,
  parameter int unsigned SP_IDX    = 15,
  parameter int unsigned FLUSH_CYC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [3:0]      id_opcode,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            ex_branch_taken,
  input  logic            dm_ready,
  output logic [3:0]      id_rf_rsrc,
  output logic            stall_if,
  output logic            flush_id,
  output logic [8:0]      ex_ctrl,
  output logic [1:0]      mem_ctrl,
  output logic [3:0]      wb_ctrl,
  output logic [RA_W-1:0] wb_rd,
  output logic            illegal_op
`ifdef FORWARD_EN
  ,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
`endif
);

  localparam int unsigned CNT_W = 2;

  ex_ctrl_t        dec_ex;
  mem_ctrl_t       dec_mem;
  wb_ctrl_t        dec_wb;
  logic [RA_W-1:0] dec_rd;
  logic [1:0]      rsrc1;
  logic [1:0]      rsrc2;

  ex_ctrl_t        e_ex;
  mem_ctrl_t       e_mem;
  wb_ctrl_t        e_wb;
  logic [RA_W-1:0] e_rd;
  mem_ctrl_t       m_mem;
  wb_ctrl_t        m_wb;
  logic [RA_W-1:0] m_rd;
  wb_ctrl_t        w_wb;
  logic [RA_W-1:0] w_rd;

  logic [CNT_W-1:0] flush_cnt;

  logic            use_a;
  logic            use_b;
  logic [RA_W-1:0] src_a;
  logic [RA_W-1:0] src_b;
  logic            mem_stall;
  logic            redirect;
  logic            flush_act;
  logic            hazard;
  logic            take_id;

  // true when a used ID source reads a live, non-r0 destination of some stage
  function automatic logic hit(input logic en, input logic [RA_W-1:0] src,
                               input logic w, input logic [RA_W-1:0] rd);
    return en && w && (rd != '0) && (rd == src);
  endfunction

  // ID-stage opcode decode into per-stage control bundles and source usage
  always_comb begin
    dec_ex  = '0;
    dec_mem = '0;
    dec_wb  = '0;
    dec_rd  = '0;
    rsrc1   = SRC_NONE;
    rsrc2   = SRC_NONE;
    case (id_opcode)
      4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
        dec_ex.aluop = id_opcode[2:0];
        dec_wb       = WB_ALU;
        dec_rd       = id_rd;
        rsrc1        = SRC_RS;
        rsrc2        = SRC_RS;
      end
      4'b0100: begin
        dec_ex.alu_src2 = 2'b10;
        dec_wb          = WB_ALU;
        dec_rd          = id_rd;
        rsrc1           = SRC_RS;
      end
      4'b0101, 4'b0110, 4'b0111: begin
        dec_ex.alu_src2 = 2'b01;
        dec_ex.aluop    = id_opcode[2:0];
        dec_wb          = WB_ALU;
        dec_rd          = id_rd;
        rsrc1           = SRC_RS;
      end
      4'b1000: begin
        dec_ex.alu_src1 = 1'b1;
        dec_ex.alu_src2 = 2'b11;
        dec_mem.dm_read = 1'b1;
        dec_wb          = WB_MEM;
        dec_rd          = id_rd;
        rsrc1           = SRC_RS;
      end
      4'b1001: begin
        dec_mem.dm_write = 1'b1;
        rsrc1            = SRC_RS;
        rsrc2            = SRC_RS;
      end
      4'b1010: begin
        dec_wb = WB_LHB;
        dec_rd = id_rd;
        rsrc1  = SRC_RS;
      end
      4'b1011: begin
        dec_wb = WB_LLB;
        dec_rd = id_rd;
        rsrc1  = SRC_RS;
      end
      4'b1100: begin
        dec_ex.sel_branch = 1'b1;
      end
      4'b1101: begin
        dec_ex.sel_call  = 1'b1;
        dec_ex.aluop     = 3'b001;
        dec_mem.dm_write = 1'b1;
        dec_wb           = WB_SP;
        dec_rd           = RA_W'(SP_IDX);
        rsrc1            = SRC_SP;
      end
      4'b1110: begin
        dec_ex.pc_src   = 1'b1;
        dec_ex.aluop    = 3'b000;
        dec_mem.dm_read = 1'b1;
        dec_wb          = WB_SP;
        dec_rd          = RA_W'(SP_IDX);
        rsrc1           = SRC_SP;
      end
      default: ;
    endcase
  end

  assign id_rf_rsrc = {rsrc1, rsrc2};
  assign src_a      = (rsrc1 == SRC_SP) ? RA_W'(SP_IDX) : id_rs1;
  assign src_b      = id_rs2;
  assign use_a      = id_valid && (rsrc1 != SRC_NONE);
  assign use_b      = id_valid && (rsrc2 != SRC_NONE);

  assign mem_stall = (m_mem.dm_read || m_mem.dm_write) && !dm_ready;
  assign redirect  = (e_ex.sel_branch && ex_branch_taken) || e_ex.sel_call || e_ex.pc_src;
  assign flush_act = redirect || (flush_cnt != '0);

  // data-hazard detection against instructions still ahead of ID
  always_comb begin
    hazard = 1'b0;
`ifdef FORWARD_EN
    hazard = e_mem.dm_read &&
             (hit(use_a, src_a, e_wb.rf_w, e_rd) || hit(use_b, src_b, e_wb.rf_w, e_rd));
`else
    hazard = hit(use_a, src_a, e_wb.rf_w, e_rd) || hit(use_b, src_b, e_wb.rf_w, e_rd) ||
             hit(use_a, src_a, m_wb.rf_w, m_rd) || hit(use_b, src_b, m_wb.rf_w, m_rd) ||
             hit(use_a, src_a, w_wb.rf_w, w_rd) || hit(use_b, src_b, w_wb.rf_w, w_rd);
`endif
  end

  // memory wait dominates; an active flush masks hazards on the wrong-path ID
  assign stall_if = mem_stall || (!flush_act && hazard);
  assign flush_id = !mem_stall && flush_act;
  assign take_id  = id_valid && !flush_act && !hazard;

  // flush down-counter: covers the cycles after the redirect cycle itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (!mem_stall) begin
      if (redirect) begin
        flush_cnt <= CNT_W'(FLUSH_CYC - 1);
      end else if (flush_cnt != '0) begin
        flush_cnt <= flush_cnt - CNT_W'(1);
      end
    end
  end

  // pipeline control registers; a memory wait freezes EX/MEM and bubbles WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_ex       <= '0;
      e_mem      <= '0;
      e_wb       <= '0;
      e_rd       <= '0;
      m_mem      <= '0;
      m_wb       <= '0;
      m_rd       <= '0;
      w_wb       <= WB_RESET;
      w_rd       <= '0;
      illegal_op <= 1'b0;
    end else if (mem_stall) begin
      w_wb       <= '0;
      w_rd       <= '0;
      illegal_op <= 1'b0;
    end else begin
      e_ex       <= take_id ? dec_ex  : '0;
      e_mem      <= take_id ? dec_mem : '0;
      e_wb       <= take_id ? dec_wb  : '0;
      e_rd       <= take_id ? dec_rd  : '0;
      m_mem      <= e_mem;
      m_wb       <= e_wb;
      m_rd       <= e_rd;
      w_wb       <= m_wb;
      w_rd       <= m_rd;
      illegal_op <= take_id && (id_opcode == OP_ILL);
    end
  end

`ifdef FORWARD_EN
  // operand bypass select for the instruction entering EX; youngest writer wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end else if (!mem_stall) begin
      if (!take_id) begin
        fwd_a <= 2'b00;
        fwd_b <= 2'b00;
      end else begin
        fwd_a <= hit(use_a, src_a, e_wb.rf_w, e_rd) ? 2'b01 :
                 hit(use_a, src_a, m_wb.rf_w, m_rd) ? 2'b10 : 2'b00;
        fwd_b <= hit(use_b, src_b, e_wb.rf_w, e_rd) ? 2'b01 :
                 hit(use_b, src_b, m_wb.rf_w, m_rd) ? 2'b10 : 2'b00;
      end
    end
  end
`endif

  assign ex_ctrl  = e_ex;
  assign mem_ctrl = m_mem;
  assign wb_ctrl  = w_wb;
  assign wb_rd    = w_rd;

endmodule
